// File: rtl/delay_tap_ctrl.sv
// Tap-setting controller for one output delay line: steps CE/INC one tap
// at a time with EN_VTC dropped, and verifies each step against CNTVALUEOUT.
module delay_tap_ctrl #(
    parameter int NUM_TAPS      = 6,
    parameter int CNT_W         = 9,
    parameter int VTC_WAIT      = 2,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [CNT_W-1:0] req_tap,
    output logic             dly_ce,
    output logic             dly_inc,
    output logic             dly_en_vtc,
    input  logic [CNT_W-1:0] dly_cntvalue,
    output logic [CNT_W-1:0] cur_tap,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int WMAX = (VTC_WAIT > SETTLE_CYCLES) ? VTC_WAIT : SETTLE_CYCLES;
    localparam int TW   = $clog2(WMAX + 1);

    localparam logic [CNT_W-1:0] MAX_TAP = CNT_W'(NUM_TAPS);
    localparam logic [TW-1:0]    VTC_LD  = TW'(VTC_WAIT - 1);
    localparam logic [TW-1:0]    SET_LD  = TW'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        VTC_OFF,
        STEP,
        SETTLE,
        CHECK,
        VTC_ON
    } state_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic [CNT_W-1:0] tgt_q, tgt_d;
    logic [CNT_W-1:0] tap_d;
    logic [CNT_W-1:0] req_clamp, cnt_clamp;
    logic             inc_d, err_d;
    logic             ce_d, en_vtc_d, ready_d, busy_d, done_d;
    logic             accept;

    assign req_clamp = (req_tap > MAX_TAP) ? MAX_TAP : req_tap;
    assign cnt_clamp = (dly_cntvalue > MAX_TAP) ? MAX_TAP : dly_cntvalue;
    assign accept    = req_valid && req_ready;

    // VTC_ON also accepts so the next request can start on the edge ending done.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        tgt_d   = tgt_q;
        tap_d   = cur_tap;
        inc_d   = dly_inc;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE, VTC_ON: begin
                state_d = IDLE;
                if (accept) begin
                    tgt_d = req_clamp;
                    if (req_clamp == cur_tap) begin
                        state_d = VTC_ON;
                    end else begin
                        state_d = VTC_OFF;
                        tmr_d   = VTC_LD;
                    end
                end
            end
            VTC_OFF: begin
                if (tmr_q == '0) begin
                    state_d = STEP;
                    inc_d   = (tgt_q > cur_tap);
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            STEP: begin
                tap_d   = dly_inc ? cur_tap + 1'b1 : cur_tap - 1'b1;
                state_d = SETTLE;
                tmr_d   = SET_LD;
            end
            SETTLE: begin
                if (tmr_q == '0) begin
                    state_d = CHECK;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            CHECK: begin
                if (dly_cntvalue != cur_tap) begin
                    tap_d   = cnt_clamp;
                    err_d   = 1'b1;
                    state_d = VTC_ON;
                end else if (cur_tap == tgt_q) begin
                    state_d = VTC_ON;
                end else begin
                    state_d = STEP;
                    inc_d   = (tgt_q > cur_tap);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they come straight off flops.
    always_comb begin
        ready_d  = (state_d == IDLE) || (state_d == VTC_ON);
        en_vtc_d = ready_d;
        busy_d   = !ready_d;
        ce_d     = (state_d == STEP);
        done_d   = (state_d == VTC_ON);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            tmr_q      <= '0;
            tgt_q      <= '0;
            cur_tap    <= '0;
            dly_inc    <= 1'b0;
            dly_ce     <= 1'b0;
            dly_en_vtc <= 1'b1;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            tgt_q      <= tgt_d;
            cur_tap    <= tap_d;
            dly_inc    <= inc_d;
            dly_ce     <= ce_d;
            dly_en_vtc <= en_vtc_d;
            req_ready  <= ready_d;
            busy       <= busy_d;
            done       <= done_d;
            err        <= err_d;
        end
    end

endmodule

// File: tb/tb_delay_tap_ctrl.sv
// Bench for delay_tap_ctrl: table vectors, corner sequences and random
// requests against a cycle-count model of the tap stepping.
module tb_delay_tap_ctrl;

    localparam int NT = 6;
    localparam int CW = 9;
    localparam int VW = 2;
    localparam int SC = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic          req_valid;
    logic          req_ready;
    logic [CW-1:0] req_tap;
    logic          dly_ce;
    logic          dly_inc;
    logic          dly_en_vtc;
    logic [CW-1:0] dly_cntvalue;
    logic [CW-1:0] cur_tap;
    logic          busy;
    logic          done;
    logic          err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    delay_tap_ctrl #(
        .NUM_TAPS(NT), .CNT_W(CW), .VTC_WAIT(VW), .SETTLE_CYCLES(SC)
    ) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_tap(req_tap),
        .dly_ce(dly_ce), .dly_inc(dly_inc), .dly_en_vtc(dly_en_vtc),
        .dly_cntvalue(dly_cntvalue), .cur_tap(cur_tap),
        .busy(busy), .done(done), .err(err)
    );

    // Delay line: saturating tap counter stepped by CE/INC, reset with RST.
    int   line_cnt;
    logic force_zero;

    always @(posedge CLK or posedge RST) begin
        if (RST) line_cnt <= 0;
        else if (dly_ce) begin
            if (dly_inc && line_cnt < NT) line_cnt <= line_cnt + 1;
            else if (!dly_inc && line_cnt > 0) line_cnt <= line_cnt - 1;
        end
    end

    assign dly_cntvalue = force_zero ? '0 : CW'(line_cnt);

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int exp_done(input int n);
        return (n == 0) ? 1 : VW + n * (SC + 2) + 1;
    endfunction

    task automatic chk_reset_vals(input string nm);
        chk({nm, ".ready"}, req_ready, 1);
        chk({nm, ".ce"}, dly_ce, 0);
        chk({nm, ".inc"}, dly_inc, 0);
        chk({nm, ".en_vtc"}, dly_en_vtc, 1);
        chk({nm, ".cur_tap"}, cur_tap, 0);
        chk({nm, ".busy"}, busy, 0);
        chk({nm, ".done"}, done, 0);
        chk({nm, ".err"}, err, 0);
    endtask

    int o_done, o_nce, o_ce1, o_cel, o_vlow, o_incbad, o_ovl, o_err, o_vad;

    // Call at a negedge with req_ready high; returns at the done cycle.
    task automatic run_req(input int tap, input int dir);
        o_done = -1; o_nce = 0; o_ce1 = -1; o_cel = -1; o_vlow = 0;
        o_incbad = 0; o_ovl = 0; o_err = 0; o_vad = 0;
        req_tap   = CW'(tap);
        req_valid = 1'b1;
        @(posedge CLK);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge CLK);
            if (dly_ce) begin
                o_nce++;
                if (o_ce1 < 0) o_ce1 = k;
                o_cel = k;
                if (dly_inc !== dir[0]) o_incbad++;
                if (dly_en_vtc) o_ovl++;
            end
            if (!dly_en_vtc) o_vlow++;
            if (done) begin
                o_done = k;
                o_err  = int'(err);
                o_vad  = int'(dly_en_vtc);
                break;
            end
            if (err) o_err = 2;
        end
    endtask

    typedef struct {
        int tap;
        int dir;
        int e_done;
        int e_tap;
        int e_nce;
        int e_ce1;
        int e_cel;
    } vec_t;

    vec_t tbl[7];

    int cur, tgt, n, t, idle, k1, k2, bsy1, rdy1;

    initial begin
        tbl[0] = '{3,   1, 21, 3, 3, 3,  15};
        tbl[1] = '{1,   0, 15, 1, 2, 3,  9};
        tbl[2] = '{0,   0, 9,  0, 1, 3,  3};
        tbl[3] = '{9,   1, 39, 6, 6, 3,  33};
        tbl[4] = '{6,   1, 1,  6, 0, -1, -1};
        tbl[5] = '{511, 1, 1,  6, 0, -1, -1};
        tbl[6] = '{2,   0, 27, 2, 4, 3,  21};

        RST = 1'b0; req_valid = 1'b0; req_tap = '0; force_zero = 1'b0;
        #2 RST = 1'b1;
        repeat (2) @(negedge CLK);
        chk_reset_vals("rst");
        RST = 1'b0;
        @(negedge CLK);
        chk_reset_vals("post_rst");

        foreach (tbl[i]) begin
            run_req(tbl[i].tap, tbl[i].dir);
            chk($sformatf("v%0d.done_cyc", i), o_done, tbl[i].e_done);
            chk($sformatf("v%0d.cur_tap", i), cur_tap, tbl[i].e_tap);
            chk($sformatf("v%0d.line", i), line_cnt, tbl[i].e_tap);
            chk($sformatf("v%0d.err", i), o_err, 0);
            chk($sformatf("v%0d.nce", i), o_nce, tbl[i].e_nce);
            chk($sformatf("v%0d.ce1", i), o_ce1, tbl[i].e_ce1);
            chk($sformatf("v%0d.cel", i), o_cel, tbl[i].e_cel);
            chk($sformatf("v%0d.vlow", i), o_vlow,
                (tbl[i].e_done > 1) ? tbl[i].e_done - 1 : 0);
            chk($sformatf("v%0d.incbad", i), o_incbad, 0);
            chk($sformatf("v%0d.ovl", i), o_ovl, 0);
            chk($sformatf("v%0d.vtc_done", i), o_vad, 1);
            chk($sformatf("v%0d.ready", i), req_ready, 1);
        end

        // Readback stuck at 0: single step, then error exit.
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        force_zero = 1'b1;
        run_req(2, 1);
        chk("bad.done_cyc", o_done, 9);
        chk("bad.err", o_err, 1);
        chk("bad.cur_tap", cur_tap, 0);
        chk("bad.nce", o_nce, 1);
        chk("bad.vtc_done", o_vad, 1);
        force_zero = 1'b0;
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;

        // Reset during SETTLE of a 4-step request.
        req_tap = CW'(4); req_valid = 1'b1;
        @(posedge CLK);
        #1 req_valid = 1'b0;
        repeat (5) @(negedge CLK);
        chk("mid.busy", busy, 1);
        chk("mid.cur_tap", cur_tap, 1);
        #2 RST = 1'b1;
        #1 chk_reset_vals("mid_rst");
        k1 = 0;
        repeat (3) begin
            @(negedge CLK);
            if (done) k1++;
        end
        chk("mid.no_done", k1, 0);
        RST = 1'b0;
        chk("mid.line", line_cnt, 0);
        run_req(2, 1);
        chk("mid2.done_cyc", o_done, 15);
        chk("mid2.cur_tap", cur_tap, 2);
        chk("mid2.err", o_err, 0);

        // req_valid held high while busy, req_tap changing.
        req_tap = CW'(5); req_valid = 1'b1;
        @(posedge CLK);
        k1 = -1; bsy1 = 0; rdy1 = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge CLK);
            if (k == 1) bsy1 = int'(busy);
            if (done) begin
                k1 = k;
                rdy1 = int'(req_ready);
                break;
            end
            req_tap = CW'($urandom_range(0, 6));
        end
        chk("hold.done_cyc", k1, 21);
        chk("hold.busy", bsy1, 1);
        chk("hold.ready", rdy1, 1);
        chk("hold.cur_tap", cur_tap, 5);
        req_tap = CW'(4);
        @(posedge CLK);
        #1 req_valid = 1'b0;
        k2 = -1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge CLK);
            if (done) begin
                k2 = k;
                break;
            end
        end
        chk("hold2.done_cyc", k2, 9);
        chk("hold2.cur_tap", cur_tap, 4);

        // Random requests against the step-count model.
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        cur = 0;
        for (int i = 0; i < 25; i++) begin
            t    = int'($urandom_range(0, 12));
            idle = int'($urandom_range(0, 3));
            repeat (idle) @(negedge CLK);
            tgt = (t > NT) ? NT : t;
            n   = (tgt > cur) ? tgt - cur : cur - tgt;
            run_req(t, (tgt > cur) ? 1 : 0);
            chk($sformatf("r%0d.done_cyc", i), o_done, exp_done(n));
            chk($sformatf("r%0d.cur_tap", i), cur_tap, tgt);
            chk($sformatf("r%0d.nce", i), o_nce, n);
            chk($sformatf("r%0d.vlow", i), o_vlow, (n > 0) ? exp_done(n) - 1 : 0);
            chk($sformatf("r%0d.incbad", i), o_incbad, 0);
            chk($sformatf("r%0d.err", i), o_err, 0);
            chk($sformatf("r%0d.line", i), line_cnt, tgt);
            cur = tgt;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/delay_tap_ctrl.md
# delay_tap_ctrl

Tap-setting controller that drives the CE/INC/EN_VTC control port of one output delay line (the ODELAYE3 model) and reads back its CNTVALUEOUT. It accepts a target tap over a valid/ready request, disables VT compensation, and steps the delay one tap at a time with a settle interval after each step. It verifies every step against the delay line's counter, then restores EN_VTC. It sits between the calibration/training logic and each delay line instance; CLK and RST are shared with the delay line.

## Interface
Parameters:
- NUM_TAPS, 6, maximum tap index; must equal the delay line's cascade count.
- CNT_W, 9, width of tap values; matches CNTVALUEOUT.
- VTC_WAIT, 2, cycles EN_VTC is held low before the first step (>=1).
- SETTLE_CYCLES, 4, idle cycles after each CE pulse before readback (>=1).

Ports:
- CLK  in  1  clock; rising edge.
- RST  in  1  reset, asynchronous, active-high; also resets the delay line.
- req_valid  in  1  tap request valid.
- req_ready  out  1  controller can accept a request.
- req_tap  in  CNT_W  requested tap; values > NUM_TAPS are clamped to NUM_TAPS.
- dly_ce  out  1  step strobe to the delay line's CE.
- dly_inc  out  1  step direction to INC; 1 = increment.
- dly_en_vtc  out  1  to EN_VTC; low only while stepping.
- dly_cntvalue  in  CNT_W  from the delay line's CNTVALUEOUT.
- cur_tap  out  CNT_W  controller's tap tracking value.
- busy  out  1  request in progress.
- done  out  1  one-cycle pulse at request completion.
- err  out  1  one-cycle pulse with done on readback mismatch.

## Operation
- All outputs are registered. Reset values: req_ready=1, dly_ce=0, dly_inc=0, dly_en_vtc=1, cur_tap=0, busy=0, done=0, err=0.
- A request is accepted on an edge with req_valid && req_ready. The clamped target is latched. While busy, req_valid is ignored.
- FSM states are IDLE, VTC_OFF, STEP, SETTLE, CHECK and VTC_ON.
- IDLE: on accept, if target == cur_tap, go to VTC_ON directly without dropping EN_VTC. Otherwise go to VTC_OFF.
- VTC_OFF: dly_en_vtc=0 for VTC_WAIT cycles, then go to STEP.
- STEP: dly_ce=1 for exactly one cycle, with dly_inc = (target > cur_tap). On the closing edge, cur_tap moves +/-1. Then go to SETTLE.
- SETTLE: SETTLE_CYCLES cycles with dly_ce=0, then go to CHECK.
- CHECK: one cycle that compares dly_cntvalue with cur_tap.
  - Mismatch: cur_tap loads dly_cntvalue, err is set, go to VTC_ON.
  - Match with cur_tap == target: go to VTC_ON.
  - Otherwise: go to STEP.
- VTC_ON: for one cycle, dly_en_vtc=1, done=1, req_ready=1 and busy=0. Then go to IDLE.
- dly_inc holds its last value outside STEP. dly_ce is never high while dly_en_vtc is high.
- cur_tap never leaves the range 0..NUM_TAPS.
- RST mid-operation: all outputs return to their reset values immediately and the FSM returns to IDLE. No done pulse is generated. Because the delay line resets too, the two stay consistent.

## Timing
- Cycle k is the cycle after edge Ek; E0 is the accept edge.
- For an N-step move (N >= 1):
  - dly_en_vtc is low in cycles 1..VTC_WAIT.
  - Step i has its dly_ce pulse in cycle VTC_WAIT + 1 + (i-1)*(SETTLE_CYCLES+2).
  - done, dly_en_vtc=1 and req_ready are high in cycle VTC_WAIT + N*(SETTLE_CYCLES+2) + 1.
- With the defaults, a 1-step move gives CE in cycle 3 and done in cycle 9. A 6-step move gives done in cycle 39.
- Zero-step request: done=1 and req_ready=1 in cycle 1. dly_en_vtc stays high.
- The earliest next accept is the edge that ends the done cycle.
- On a mismatch, err and done pulse together in the cycle after CHECK. No further steps are issued for that request.

## Test plan
- Reset, then request 3: EN_VTC low in cycles 1-2, then 3 CE pulses with INC=1 at cycles 3, 9 and 15. done in cycle 21, cur_tap=3, CNTVALUEOUT=3, err=0.
- From tap 3, request 1: 2 CE pulses with INC=0. done in cycle 15, cur_tap=1, delay select=0b000001.
- Request 9 from tap 0: clamped to 6, done in cycle 39, cur_tap=6, select=0b111111. A follow-up request 6 gives done in cycle 1 and EN_VTC is never low.
- Force dly_cntvalue to stay 0 during a request of 2: err=1 with done in cycle 9, cur_tap=0, EN_VTC=1, no second CE pulse.
- Assert RST during SETTLE of a request of 4: all outputs reset asynchronously, no done pulse. A new request of 2 after release completes normally with done in cycle 15.
- Hold req_valid high while busy with changing req_tap: only the first request executes, and the next accept happens at the edge ending the done cycle.
